// File: rtl/bus_req_master.sv
// ============================================================================
// bus_req_master: bus arbiter requester, active-low request to counted burst
// Revision: 1.0
// ============================================================================
`default_nettype none

module bus_req_master #(
  parameter int LEN_W   = 4,
  parameter int HOLDOFF = 1,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             xfer_req,
  input  logic [LEN_W-1:0] xfer_len,
  input  logic             gnt,
  output logic             busy,
  output logic             nreq,
  output logic             beat,
  output logic [LEN_W-1:0] beat_cnt,
  output logic             done,
  output logic             err
);

  // Counters only need to hold HOLDOFF-1 and TIMEOUT-1 respectively.
  localparam int HO_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [HO_W-1:0] HO_LOAD = HO_W'(HOLDOFF - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, XFER, RELEASE} state_t;

  state_t           state, state_nx;
  logic [LEN_W-1:0] len, len_nx;
  logic [TO_W-1:0]  wait_cnt, wait_nx;
  logic [HO_W-1:0]  hold_cnt, hold_nx;
  logic             busy_nx, nreq_nx, beat_nx, done_nx, err_nx;
  logic [LEN_W-1:0] cnt_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len      <= '0;
      wait_cnt <= '0;
      hold_cnt <= '0;
      busy     <= 1'b0;
      nreq     <= 1'b1;
      beat     <= 1'b0;
      beat_cnt <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      len      <= len_nx;
      wait_cnt <= wait_nx;
      hold_cnt <= hold_nx;
      busy     <= busy_nx;
      nreq     <= nreq_nx;
      beat     <= beat_nx;
      beat_cnt <= cnt_nx;
      done     <= done_nx;
      err      <= err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    len_nx   = len;
    wait_nx  = wait_cnt;
    hold_nx  = hold_cnt;
    busy_nx  = busy;
    nreq_nx  = nreq;
    beat_nx  = 1'b0;
    cnt_nx   = beat_cnt;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    case (state)
      // IDLE is only re-entered once the hold-off count has drained.
      IDLE: begin
        if (xfer_req) begin
          state_nx = REQ;
          len_nx   = xfer_len;
          wait_nx  = '0;
          busy_nx  = 1'b1;
          nreq_nx  = 1'b0;
        end
      end
      REQ: begin
        if (gnt) begin
          state_nx = XFER;
          beat_nx  = 1'b1;
          cnt_nx   = '0;
          done_nx  = (len == '0);
        end else if (TIMEOUT != 0 && wait_cnt == TO_LAST) begin
          state_nx = RELEASE;
          err_nx   = 1'b1;
          nreq_nx  = 1'b1;
          hold_nx  = HO_LOAD;
        end else begin
          wait_nx = wait_cnt + 1'b1;
        end
      end
      XFER: begin
        // The arbiter may drop gnt right after done; that is not an abort.
        if (done || !gnt) begin
          state_nx = RELEASE;
          err_nx   = !done;
          nreq_nx  = 1'b1;
          cnt_nx   = '0;
          hold_nx  = HO_LOAD;
        end else begin
          beat_nx = 1'b1;
          cnt_nx  = beat_cnt + 1'b1;
          done_nx = (cnt_nx == len);
        end
      end
      RELEASE: begin
        if (hold_cnt == '0) begin
          state_nx = IDLE;
          busy_nx  = 1'b0;
        end else begin
          hold_nx = hold_cnt - 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_bus_req_master.sv
// ============================================================================
// tb_bus_req_master: randomized transactions against a cycle-sequence model
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_bus_req_master;

  localparam int LEN_W   = 4;
  localparam int HOLDOFF = 2;
  localparam int TIMEOUT = 8;

  logic             clk      = 1'b0;
  logic             rst_n    = 1'b0;
  logic             xfer_req = 1'b0;
  logic [LEN_W-1:0] xfer_len = '0;
  logic             gnt      = 1'b0;
  logic             busy, nreq, beat, done, err;
  logic [LEN_W-1:0] beat_cnt;

  int checks   = 0;
  int failures = 0;

  // One entry = inputs for one cycle plus the outputs expected after its edge.
  typedef struct {
    logic             req;
    logic [LEN_W-1:0] len;
    logic             g;
    logic             busy, nreq, beat, done, err;
    logic [LEN_W-1:0] cnt;
  } ent_t;

  ent_t q[$];

  bus_req_master #(.LEN_W(LEN_W), .HOLDOFF(HOLDOFF), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .xfer_req(xfer_req), .xfer_len(xfer_len), .gnt(gnt),
    .busy(busy), .nreq(nreq), .beat(beat), .beat_cnt(beat_cnt), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    if (obs !== want) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, want, $time);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void push(input logic req, input int len, input logic g,
                               input logic b, input logic n, input logic bt,
                               input int cnt, input logic d, input logic e);
    ent_t x;
    x.req = req; x.len = LEN_W'(len); x.g = g;
    x.busy = b; x.nreq = n; x.beat = bt; x.cnt = LEN_W'(cnt); x.done = d; x.err = e;
    q.push_back(x);
  endfunction

  // mode 0: normal, grant on REQ edge D+1; mode 1: grant never comes;
  // mode 2: grant lost at the edge ending beat K (K < L).
  task automatic build(input int L, input int mode, input int D, input int K, input int gap);
    bit granted = 1'b0;
    for (int j = 0; j < gap; j++) push(1'b0, $urandom, rb(), 0, 1, 0, 0, 0, 0);
    push(1'b1, L, 1'b0, 1, 0, 0, 0, 0, 0);
    for (int r = 1; r <= TIMEOUT; r++) begin
      if (mode != 1 && r == D + 1) begin
        push(rb(), $urandom, 1'b1, 1, 0, 1, 0, (L == 0), 0);
        granted = 1'b1;
        break;
      end
      if (r == TIMEOUT) begin
        push(rb(), $urandom, 1'b0, 1, 1, 0, 0, 0, 1);
        break;
      end
      push(rb(), $urandom, 1'b0, 1, 0, 0, 0, 0, 0);
    end
    if (granted) begin
      for (int i = 0; i <= L; i++) begin
        if (mode == 2 && i == K) begin
          push(rb(), $urandom, 1'b0, 1, 1, 0, 0, 0, 1);
          break;
        end
        if (i == L) begin
          push(rb(), $urandom, rb(), 1, 1, 0, 0, 0, 0);
          break;
        end
        push(rb(), $urandom, 1'b1, 1, 0, 1, i + 1, (i + 1 == L), 0);
      end
    end
    for (int h = 1; h < HOLDOFF; h++) push(rb(), $urandom, rb(), 1, 1, 0, 0, 0, 0);
    push(rb(), $urandom, rb(), 0, 1, 0, 0, 0, 0);
  endtask

  task automatic run_q(input int stop_cnt);
    ent_t x;
    while (q.size() > 0) begin
      x = q.pop_front();
      xfer_req = x.req;
      xfer_len = x.len;
      gnt      = x.g;
      @(posedge clk);
      #1;
      check_eq("busy", 32'(busy), 32'(x.busy));
      check_eq("nreq", 32'(nreq), 32'(x.nreq));
      check_eq("beat", 32'(beat), 32'(x.beat));
      check_eq("beat_cnt", 32'(beat_cnt), 32'(x.cnt));
      check_eq("done", 32'(done), 32'(x.done));
      check_eq("err", 32'(err), 32'(x.err));
      if (stop_cnt >= 0 && x.beat && int'(x.cnt) == stop_cnt) q.delete();
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_nreq"}, 32'(nreq), 32'd1);
    check_eq({tag, "_beat"}, 32'(beat), 32'd0);
    check_eq({tag, "_cnt"}, 32'(beat_cnt), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
    check_eq({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    int L, mode, K;
    @(posedge clk);
    #1;
    check_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed scenarios first, then random traffic.
    build(3, 0, 2, 0, 1);
    build(0, 0, 0, 0, 0);
    build(15, 0, 1, 0, 0);
    build(7, 1, 0, 0, 2);
    build(4, 0, TIMEOUT - 1, 0, 0);
    build(7, 2, 0, 4, 1);
    run_q(-1);
    for (int t = 0; t < 40; t++) begin
      mode = int'($urandom_range(0, 2));
      L    = int'($urandom_range(0, 15));
      if (mode == 2 && L == 0) L = 1;
      K    = (L > 0) ? int'($urandom_range(0, L - 1)) : 0;
      build(L, mode, int'($urandom_range(0, TIMEOUT - 1)), K, int'($urandom_range(0, 2)));
    end
    run_q(-1);

    // Reset in the middle of a burst, then a full-length burst.
    build(5, 0, 1, 0, 1);
    run_q(2);
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    xfer_req = 1'b0;
    gnt      = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_vals("held_rst");
    rst_n = 1'b1;
    push(1'b0, 0, 1'b0, 0, 1, 0, 0, 0, 0);
    build(15, 0, 0, 0, 0);
    run_q(-1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule

`default_nettype wire
